neuron_potential_array: RTL and testbench
=========================================

// Module: neuron_potential_array
// PURPOSE
//  Time-multiplexed LIF membrane-potential unit for NUM_NEURONS neurons in signed fixed point.
//  Accumulates incoming weights per neuron during a timestep. On ts_end it sweeps every neuron:
//  threshold compare, spike emission, reset-by-subtraction (V <- V - Vth) and leak decay.
//  Sits between the weight-lookup stage and the network-interface spike queue of a node.
// PARAMETERS
//  DATA_W       16  potential/weight/threshold width, signed two's complement
//  NUM_NEURONS  4   neurons held in this unit
//  NID_W        2   neuron-id width, clog2(NUM_NEURONS), minimum 1
//  DECAY_SHIFT  2   leak: V <- V - (V >>> DECAY_SHIFT); 0 clears V every step
//  REFRAC_STEPS 2   refractory timesteps after a spike (only with NPA_REFRACTORY_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  w_valid      in   1       weight offered
//  w_ready      out  1       weight accepted when w_valid & w_ready
//  w_neuron     in   NID_W   target neuron id
//  w_value      in   DATA_W  signed weight
//  ts_end       in   1       one-cycle pulse: close timestep, start sweep
//  v_threshold  in   DATA_W  signed threshold, sampled each sweep cycle
//  spike_valid  out  1       spike presented
//  spike_ready  in   1       consumer takes spike
//  spike_id     out  NID_W   id of spiking neuron
//  ts_done      out  1       one-cycle pulse: sweep complete
//  ts_overrun   out  1       one-cycle pulse: ts_end received while not in ACCUM
//  dbg_addr     in   NID_W   debug read address
//  dbg_pot      out  DATA_W  combinational read of potential[dbg_addr]
// BEHAVIOUR
//  Reset: all potentials 0, state ACCUM, index 0. w_ready, spike_valid, spike_id, ts_done
//   and ts_overrun are 0 while rst is high; w_ready rises the first cycle after release.
//  States: ACCUM -> (ts_end) SWEEP -> (spike found) EMIT -> (spike_ready) SWEEP -> (last) DONE -> ACCUM.
//  ACCUM: w_ready=1. Each accepted weight updates in that cycle: pot[id] <= sat(pot[id] + w_value).
//   Ids >= NUM_NEURONS are accepted and dropped. w_valid and ts_end in the same cycle: the weight
//   is applied, then SWEEP starts at index 0 next cycle.
//  SWEEP: w_ready=0. One neuron per cycle, index 0..NUM_NEURONS-1.
//   fire = (pot[i] >= v_threshold), signed compare.
//   v1 = fire ? sat(pot[i] - v_threshold) : pot[i].
//   pot[i] <= v1 - (v1 >>> DECAY_SHIFT), arithmetic shift.
//   If fire: go to EMIT with spike_id=i.
//  EMIT: spike_valid=1, spike_id stable until the handshake. On spike_valid & spike_ready,
//   continue at i+1, or go to DONE if i was last. No ready-to-valid combinational path.
//  DONE: ts_done=1 for one cycle, then ACCUM with w_ready=1.
//  Latency: sweep with no spikes = NUM_NEURONS cycles + 1 DONE cycle. Each spike adds
//   >= 1 EMIT cycle.
//  sat(): clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; overflow is detected on the DATA_W+1 result.
//  ts_end outside ACCUM: ignored, ts_overrun pulses next cycle, sweep unaffected.
//  rst mid-sweep or mid-EMIT: pending spike is discarded; state and potentials reset at once.
// CONFIGURATION
//  NPA_REFRACTORY_EN defined:
//   - Each neuron has a counter ref[i], width clog2(REFRAC_STEPS+1), reset 0.
//   - On fire, ref[i] <= REFRAC_STEPS.
//   - In SWEEP, a neuron with ref[i] != 0 cannot fire and ref[i] decrements.
//   - Weights accepted in ACCUM for a neuron with ref[i] != 0 are dropped.
//  NPA_REFRACTORY_EN undefined: no counters; any neuron may fire every timestep.
// TESTING (DATA_W=16, NUM_NEURONS=4, DECAY_SHIFT=2, v_threshold=100)
//  1 Basic fire: weights n1:+60, n1:+50, ts_end -> one spike id=1; pot[1]=110-100=10 -> 8;
//    other pots 0; ts_done after 4 sweep cycles + EMIT.
//  2 Saturation: n0:+30000 twice -> dbg_pot=32767. n2:-30000 twice -> -32768; n2 never fires.
//  3 Backpressure: n0, n2 over threshold, spike_ready low 5 cycles -> spike_valid held, id 0
//    stable; then ids 0, 2 in order; ts_done only after the 2nd handshake.
//  4 Edges: w_valid + ts_end in the same cycle applies the weight before sweep. ts_end during
//    SWEEP -> ts_overrun=1 for 1 cycle, no second sweep.
//  5 Async reset asserted during EMIT -> spike_valid=0 immediately; all dbg_pot=0; w_ready=1
//    the cycle after release.
//  6 NPA_REFRACTORY_EN, REFRAC_STEPS=2: n3 gets +200 every step -> fires at steps 1 and 4 only;
//    weights at steps 2-3 dropped.

Source files
------------

// File: rtl/neuron_potential_array.sv
// neuron_potential_array: time-multiplexed LIF membrane-potential unit.
// Weights accumulate per neuron while in ACCUM. On ts_end, one neuron per cycle is
// threshold-compared, reset by subtraction on a spike, and leak-decayed.
// Optional feature macro: NPA_REFRACTORY_EN adds per-neuron refractory counters.
module neuron_potential_array #(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned NUM_NEURONS  = 4,
   parameter int unsigned NID_W        = 2,
   parameter int unsigned DECAY_SHIFT  = 2,
   parameter int unsigned REFRAC_STEPS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_valid,
   output logic                     w_ready,
   input  logic [NID_W-1:0]         w_neuron,
   input  logic signed [DATA_W-1:0] w_value,
   input  logic                     ts_end,
   input  logic signed [DATA_W-1:0] v_threshold,
   output logic                     spike_valid,
   input  logic                     spike_ready,
   output logic [NID_W-1:0]         spike_id,
   output logic                     ts_done,
   output logic                     ts_overrun,
   input  logic [NID_W-1:0]         dbg_addr,
   output logic signed [DATA_W-1:0] dbg_pot
);

   localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [NID_W-1:0]         LAST_IDX = NID_W'(NUM_NEURONS - 1);

   // Reject parameter sets the id width cannot address
   if (NID_W == 0 || NUM_NEURONS == 0 || NUM_NEURONS > (1 << NID_W) ||
       DECAY_SHIFT >= DATA_W || REFRAC_STEPS > 65535) begin : g_bad_cfg
      $error("neuron_potential_array: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SWEEP = 2'd1,
      ST_EMIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                   state, state_d;
   logic [NID_W-1:0]         idx, idx_d;
   logic signed [DATA_W-1:0] pot [NUM_NEURONS];

   logic                     w_ready_d, spike_valid_d, ts_done_d, ts_overrun_d;
   logic [NID_W-1:0]         spike_id_d;

   logic                     last;
   logic                     fire;
   logic                     ref_busy;
   logic                     w_blocked;
   logic                     w_in_range;
   logic                     accept;
   logic                     wr_en;
   logic signed [DATA_W-1:0] cur_pot;
   logic signed [DATA_W-1:0] v1;
   logic signed [DATA_W-1:0] v_next;
   logic signed [DATA_W-1:0] w_sum;

   // Clamp a DATA_W+1 bit result back into DATA_W bits
   function automatic logic signed [DATA_W-1:0] sat_fit(input logic [DATA_W:0] s);
      if (s[DATA_W] != s[DATA_W-1]) begin
         return s[DATA_W] ? MIN_V : MAX_V;
      end
      return s[DATA_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      logic [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      return sat_fit(s);
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      logic [DATA_W:0] s;
      s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
      return sat_fit(s);
   endfunction

`ifdef NPA_REFRACTORY_EN
   localparam int unsigned REF_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

   logic [REF_W-1:0] ref_cnt [NUM_NEURONS];

   assign ref_busy  = (ref_cnt[idx] != '0);
   assign w_blocked = (ref_cnt[w_neuron] != '0);

   // Refractory counters: load on fire, count down once per sweep visit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_NEURONS); i++) begin
            ref_cnt[i] <= '0;
         end
      end else if (state == ST_SWEEP) begin
         if (ref_busy) begin
            ref_cnt[idx] <= ref_cnt[idx] - REF_W'(1);
         end else if (fire) begin
            ref_cnt[idx] <= REF_W'(REFRAC_STEPS);
         end
      end
   end
`else
   assign ref_busy  = 1'b0;
   assign w_blocked = 1'b0;
`endif

   // Sweep datapath for the neuron at idx
   assign cur_pot = pot[idx];
   assign last    = (idx == LAST_IDX);
   assign fire    = !ref_busy && (cur_pot >= v_threshold);
   assign v1      = fire ? sat_sub(cur_pot, v_threshold) : cur_pot;
   assign v_next  = v1 - (v1 >>> DECAY_SHIFT);

   // Weight accumulation path
   assign w_in_range = (32'(w_neuron) < NUM_NEURONS);
   assign accept     = w_valid && w_ready;
   assign wr_en      = accept && w_in_range && !w_blocked;
   assign w_sum      = sat_add(pot[w_neuron], w_value);

   assign dbg_pot = (32'(dbg_addr) < NUM_NEURONS) ? pot[dbg_addr] : '0;

   // Potential storage: sweep write-back or accepted weight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_NEURONS); i++) begin
            pot[i] <= '0;
         end
      end else if (state == ST_SWEEP) begin
         pot[idx] <= v_next;
      end else if (wr_en) begin
         pot[w_neuron] <= w_sum;
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_ACCUM;
         idx         <= '0;
         w_ready     <= 1'b0;
         spike_valid <= 1'b0;
         spike_id    <= '0;
         ts_done     <= 1'b0;
         ts_overrun  <= 1'b0;
      end else begin
         state       <= state_d;
         idx         <= idx_d;
         w_ready     <= w_ready_d;
         spike_valid <= spike_valid_d;
         spike_id    <= spike_id_d;
         ts_done     <= ts_done_d;
         ts_overrun  <= ts_overrun_d;
      end
   end

   // Next-state and sweep index
   always_comb begin
      state_d = state;
      idx_d   = idx;
      case (state)
         ST_ACCUM: begin
            if (ts_end) begin
               state_d = ST_SWEEP;
               idx_d   = '0;
            end
         end
         ST_SWEEP: begin
            if (fire) begin
               state_d = ST_EMIT;
            end else if (last) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx + NID_W'(1);
            end
         end
         ST_EMIT: begin
            if (spike_valid && spike_ready) begin
               if (last) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SWEEP;
                  idx_d   = idx + NID_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_ACCUM;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_ACCUM;
            idx_d   = '0;
         end
      endcase
   end

   // Output next values, derived from the upcoming state
   always_comb begin
      w_ready_d     = 1'b0;
      spike_valid_d = 1'b0;
      spike_id_d    = spike_id;
      ts_done_d     = 1'b0;
      ts_overrun_d  = 1'b0;
      if (state_d == ST_ACCUM) begin
         w_ready_d = 1'b1;
      end
      if (state_d == ST_EMIT) begin
         spike_valid_d = 1'b1;
      end
      if (state_d == ST_DONE) begin
         ts_done_d = 1'b1;
      end
      if (state == ST_SWEEP && fire) begin
         spike_id_d = idx;
      end
      if (ts_end && state != ST_ACCUM) begin
         ts_overrun_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_neuron_potential_array.sv
// tb_neuron_potential_array: directed, table-driven bench for neuron_potential_array.
`timescale 1ns/1ps
module tb_neuron_potential_array;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned NUM_NEURONS = 4;
   localparam int unsigned NID_W       = 2;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     w_valid = 1'b0;
   logic                     w_ready;
   logic [NID_W-1:0]         w_neuron = '0;
   logic signed [DATA_W-1:0] w_value = '0;
   logic                     ts_end = 1'b0;
   logic signed [DATA_W-1:0] v_threshold = 16'sd100;
   logic                     spike_valid;
   logic                     spike_ready = 1'b1;
   logic [NID_W-1:0]         spike_id;
   logic                     ts_done;
   logic                     ts_overrun;
   logic [NID_W-1:0]         dbg_addr = '0;
   logic signed [DATA_W-1:0] dbg_pot;

   neuron_potential_array #(
      .DATA_W      (DATA_W),
      .NUM_NEURONS (NUM_NEURONS),
      .NID_W       (NID_W),
      .DECAY_SHIFT (2),
      .REFRAC_STEPS(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_neuron   (w_neuron),
      .w_value    (w_value),
      .ts_end     (ts_end),
      .v_threshold(v_threshold),
      .spike_valid(spike_valid),
      .spike_ready(spike_ready),
      .spike_id   (spike_id),
      .ts_done    (ts_done),
      .ts_overrun (ts_overrun),
      .dbg_addr   (dbg_addr),
      .dbg_pot    (dbg_pot)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;
      int v;
      int exp_pot;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int spk_cnt;
   int spk_ids [8];
   int sweep_cycles;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_pot(input int n, input int exp);
      dbg_addr = NID_W'(n);
      #1;
      check($sformatf("pot[%0d]", n), $signed(dbg_pot), exp);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      w_valid     = 1'b0;
      ts_end      = 1'b0;
      spike_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic apply_w(input int n, input int v, input logic with_ts);
      check("w_ready before weight", w_ready, 1);
      w_valid  = 1'b1;
      w_neuron = NID_W'(n);
      w_value  = DATA_W'(v);
      ts_end   = with_ts;
      tick();
      w_valid = 1'b0;
      ts_end  = 1'b0;
   endtask

   task automatic start_sweep();
      ts_end = 1'b1;
      tick();
      ts_end = 1'b0;
   endtask

   // Log handshaken spikes until ts_done, bounded
   task automatic collect();
      spk_cnt      = 0;
      sweep_cycles = 0;
      while (!ts_done && sweep_cycles < 60) begin
         if (spike_valid && spike_ready && spk_cnt < 8) begin
            spk_ids[spk_cnt] = int'(spike_id);
            spk_cnt++;
         end
         tick();
         sweep_cycles++;
      end
      check("ts_done reached", ts_done, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [8];
      int   exp_fire [4];
      int   exp_p3 [4];
      int   extra;

      tbl[0] = '{0,  30000,  30000};
      tbl[1] = '{0,  30000,  32767};
      tbl[2] = '{2, -30000, -30000};
      tbl[3] = '{2, -30000, -32768};
      tbl[4] = '{1,     60,     60};
      tbl[5] = '{1,   -100,    -40};
      tbl[6] = '{0,     -1,  32766};
      tbl[7] = '{2,      5, -32763};

`ifdef NPA_REFRACTORY_EN
      exp_fire = '{1, 0, 0, 1};
      exp_p3   = '{75, 57, 43, 108};
`else
      exp_fire = '{1, 1, 1, 1};
      exp_p3   = '{75, 132, 174, 206};
`endif

      // Reset state
      #2;
      check("w_ready in reset", w_ready, 0);
      check("spike_valid in reset", spike_valid, 0);
      check("ts_done in reset", ts_done, 0);
      check("ts_overrun in reset", ts_overrun, 0);
      do_reset();
      check("w_ready after release", w_ready, 1);
      for (int i = 0; i < 4; i++) check_pot(i, 0);

      // Basic fire
      apply_w(1, 60, 1'b0);
      apply_w(1, 50, 1'b0);
      check_pot(1, 110);
      start_sweep();
      collect();
      check("t1 spike count", spk_cnt, 1);
      check("t1 spike id", spk_ids[0], 1);
      check("t1 sweep cycles", sweep_cycles, 5);
      tick();
      check("t1 w_ready after done", w_ready, 1);
      check("t1 ts_done one cycle", ts_done, 0);
      check_pot(0, 0);
      check_pot(1, 8);
      check_pot(2, 0);
      check_pot(3, 0);

      // Saturation table
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply_w(tbl[i].n, tbl[i].v, 1'b0);
         check_pot(tbl[i].n, tbl[i].exp_pot);
      end
      start_sweep();
      collect();
      check("t2 spike count", spk_cnt, 1);
      check("t2 spike id", spk_ids[0], 0);
      check("t2 sweep cycles", sweep_cycles, 5);
      tick();
      check_pot(0, 24500);
      check_pot(1, -30);
      check_pot(2, -24572);
      check_pot(3, 0);

      // Backpressure
      do_reset();
      apply_w(0, 150, 1'b0);
      apply_w(2, 120, 1'b0);
      spike_ready = 1'b0;
      start_sweep();
      for (int k = 0; k < 10 && !spike_valid; k++) tick();
      check("t3 spike_valid", spike_valid, 1);
      check("t3 first id", spike_id, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3 held valid", spike_valid, 1);
         check("t3 held id", spike_id, 0);
         check("t3 no early done", ts_done, 0);
      end
      spike_ready = 1'b1;
      collect();
      check("t3 spike count", spk_cnt, 2);
      check("t3 id0", spk_ids[0], 0);
      check("t3 id1", spk_ids[1], 2);
      tick();
      check_pot(0, 38);
      check_pot(2, 15);

      // Weight and ts_end in the same cycle
      do_reset();
      apply_w(1, 150, 1'b1);
      collect();
      check("t4 spike count", spk_cnt, 1);
      check("t4 spike id", spk_ids[0], 1);
      check("t4 sweep cycles", sweep_cycles, 5);
      tick();
      check_pot(1, 38);

      // ts_end during sweep
      do_reset();
      start_sweep();
      ts_end = 1'b1;
      tick();
      ts_end = 1'b0;
      check("t4 overrun pulse", ts_overrun, 1);
      tick();
      check("t4 overrun cleared", ts_overrun, 0);
      collect();
      check("t4 remaining cycles", sweep_cycles, 2);
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (ts_done || !w_ready) extra++;
      end
      check("t4 no second sweep", extra, 0);

      // Async reset during EMIT
      do_reset();
      apply_w(1, 200, 1'b0);
      spike_ready = 1'b0;
      start_sweep();
      for (int k = 0; k < 10 && !spike_valid; k++) tick();
      check("t5 in emit", spike_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("t5 valid dropped", spike_valid, 0);
      check("t5 w_ready low", w_ready, 0);
      for (int i = 0; i < 4; i++) check_pot(i, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      spike_ready = 1'b1;
      check("t5 w_ready at release", w_ready, 0);
      tick();
      check("t5 w_ready after release", w_ready, 1);
      check("t5 no stale done", ts_done, 0);

      // Repeated drive of neuron 3 across timesteps
      do_reset();
      for (int s = 0; s < 4; s++) begin
         apply_w(3, 200, 1'b0);
         start_sweep();
         collect();
         tick();
         check($sformatf("t6 step%0d spikes", s + 1), spk_cnt, exp_fire[s]);
         check_pot(3, exp_p3[s]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
